// File: rtl/seq_shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// seq_shift_add_multiplier_if : start/done handshake and operand/result bus
// Rev 1.0
// ============================================================================
interface seq_shift_add_multiplier_if #(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 4
);
  logic                       start;
  logic                       signed_mode;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
  logic                       busy;
  logic                       done;
  logic [A_WIDTH+B_WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// seq_shift_add_multiplier : one partial product per clock, shared adder
// Rev 1.0
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  seq_shift_add_multiplier_if.slave bus
);
  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int CNT_WIDTH = $clog2(A_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(A_WIDTH - 1);

  // Encoding chosen so busy/done are direct state-register bits.
  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_RUN  = 2'b01;
  localparam logic [1:0] c_DONE = 2'b10;

  logic [1:0]           state_q, state_d;
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [P_WIDTH-1:0]   acc_q;
  logic [P_WIDTH-1:0]   product_q;

  logic                 w_accept;
  logic                 w_last;
  logic [P_WIDTH-1:0]   w_b_ext;
  logic [P_WIDTH-1:0]   w_term;
  logic [P_WIDTH-1:0]   w_acc_next;

  assign w_accept = bus.start && ((state_q == c_IDLE) || (state_q == c_DONE));
  assign w_last   = (cnt_q == c_LAST);
  assign w_b_ext  = mode_q ? {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q} : {{A_WIDTH{1'b0}}, b_q};
  assign w_term   = w_b_ext << cnt_q;

  // The multiplier MSB has negative weight in signed mode.
  always_comb begin
    w_acc_next = acc_q;
    if (a_q[cnt_q]) begin
      if (w_last && mode_q) begin
        w_acc_next = acc_q - w_term;
      end else begin
        w_acc_next = acc_q + w_term;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (bus.start) state_d = c_RUN;
      c_RUN:   if (w_last) state_d = c_DONE;
      c_DONE:  state_d = bus.start ? c_RUN : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == c_RUN);
    bus.done    = (state_q == c_DONE);
    bus.product = product_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (w_accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      mode_q <= bus.signed_mode;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == c_RUN) begin
      acc_q <= w_acc_next;
      if (w_last) begin
        product_q <= w_acc_next;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// tb_seq_shift_add_multiplier : vector table, corner sequences, model check
// Rev 1.0
// ============================================================================
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.A_WIDTH(3), .B_WIDTH(4)) bus_s ();
  seq_shift_add_multiplier_if #(.A_WIDTH(8), .B_WIDTH(8)) bus_w ();

  seq_shift_add_multiplier #(.A_WIDTH(3), .B_WIDTH(4)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  typedef struct {
    logic [2:0] a;
    logic [3:0] b;
    logic       m;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_s(input logic [2:0] a, input logic [3:0] b, input logic m);
    int av, bv, p;
    av = int'(a);
    bv = int'(b);
    if (m && a[2]) av -= 8;
    if (m && b[3]) bv -= 16;
    p = av * bv;
    return p[6:0];
  endfunction

  function automatic logic [15:0] ref_w(input logic [7:0] a, input logic [7:0] b, input logic m);
    int av, bv, p;
    av = int'(a);
    bv = int'(b);
    if (m && a[7]) av -= 256;
    if (m && b[7]) bv -= 256;
    p = av * bv;
    return p[15:0];
  endfunction

  task automatic run_s(input logic [2:0] a, input logic [3:0] b, input logic m,
                       output logic [6:0] p, output int lat, output int bc);
    @(negedge clk);
    bus_s.a = a; bus_s.b = b; bus_s.signed_mode = m; bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.start = 1'b0;
    lat = -1; bc = 0; p = '0;
    for (int c = 0; c < 20; c++) begin
      if (bus_s.done) begin
        lat = c;
        p = bus_s.product;
        break;
      end
      if (bus_s.busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic run_w(input logic [7:0] a, input logic [7:0] b, input logic m,
                       output logic [15:0] p, output int lat);
    @(negedge clk);
    bus_w.a = a; bus_w.b = b; bus_w.signed_mode = m; bus_w.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_w.start = 1'b0;
    lat = -1; p = '0;
    for (int c = 0; c < 30; c++) begin
      if (bus_w.done) begin
        lat = c;
        p = bus_w.product;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  p;
    logic [15:0] pw;
    int          lat, bc, seen, efail, lfail;

    vecs[0] = '{3'd7, 4'd15, 1'b0, 7'h69};
    vecs[1] = '{3'd7, 4'd5,  1'b1, 7'h7B};
    vecs[2] = '{3'd4, 4'd8,  1'b1, 7'h20};
    vecs[3] = '{3'd5, 4'd13, 1'b0, 7'h41};
    vecs[4] = '{3'd3, 4'd6,  1'b0, 7'h12};
    vecs[5] = '{3'd3, 4'd8,  1'b1, 7'h68};
    vecs[6] = '{3'd0, 4'd0,  1'b0, 7'h00};
    vecs[7] = '{3'd2, 4'd15, 1'b1, 7'h7E};
    vecs[8] = '{3'd5, 4'd3,  1'b1, 7'h77};

    bus_s.start = 1'b0; bus_s.a = '0; bus_s.b = '0; bus_s.signed_mode = 1'b0;
    bus_w.start = 1'b0; bus_w.a = '0; bus_w.b = '0; bus_w.signed_mode = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus_s.busy), 32'd0);
    check("reset_done", 32'(bus_s.done), 32'd0);
    check("reset_product", 32'(bus_s.product), 32'd0);
    check("reset_product_w", 32'(bus_w.product), 32'd0);
    rst_n = 1'b1;

    // Unsigned max operands, busy length, latency, then hold
    run_s(3'd7, 4'd15, 1'b0, p, lat, bc);
    check("first_product", 32'(p), 32'd105);
    check("first_latency", 32'(lat), 32'd3);
    check("first_busy_cycles", 32'(bc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_product_%0d", i), 32'(bus_s.product), 32'd105);
      check($sformatf("hold_done_%0d", i), 32'(bus_s.done), 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      run_s(vecs[i].a, vecs[i].b, vecs[i].m, p, lat, bc);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // start held through RUN with operands changing, then back-to-back accept on DONE
    @(negedge clk);
    bus_s.a = 3'd3; bus_s.b = 4'd6; bus_s.signed_mode = 1'b0; bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.a = 3'd0; bus_s.b = 4'd0;
    check("held_busy_c0", 32'(bus_s.busy), 32'd1);
    repeat (3) @(negedge clk);
    check("held_done_c3", 32'(bus_s.done), 32'd1);
    check("held_product", 32'(bus_s.product), 32'd18);
    @(negedge clk);
    bus_s.start = 1'b0;
    check("b2b_done_not_repeated", 32'(bus_s.done), 32'd0);
    check("b2b_busy", 32'(bus_s.busy), 32'd1);
    check("b2b_product_held", 32'(bus_s.product), 32'd18);
    repeat (3) @(negedge clk);
    check("b2b_done", 32'(bus_s.done), 32'd1);
    check("b2b_product", 32'(bus_s.product), 32'd0);

    // Async reset in the second RUN cycle aborts the operation
    run_s(3'd7, 4'd15, 1'b0, p, lat, bc);
    check("pre_reset_product", 32'(p), 32'd105);
    @(negedge clk);
    bus_s.a = 3'd5; bus_s.b = 4'd13; bus_s.signed_mode = 1'b0; bus_s.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(bus_s.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus_s.busy), 32'd0);
    check("abort_done", 32'(bus_s.done), 32'd0);
    check("abort_product", 32'(bus_s.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_s.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_s(3'd5, 4'd13, 1'b0, p, lat, bc);
    check("post_abort_product", 32'(p), 32'd65);
    check("post_abort_latency", 32'(lat), 32'd3);

    // Exhaustive small instance against the arithmetic model
    efail = 0;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 16; b++) begin
          run_s(3'(a), 4'(b), 1'(m), p, lat, bc);
          check($sformatf("exh_m%0d_a%0d_b%0d", m, a, b), 32'(p), 32'(ref_s(3'(a), 4'(b), 1'(m))));
          if (lat != 3) efail++;
        end
      end
    end
    check("exh_latency_errors", 32'(efail), 32'd0);

    // Random wide instance
    lfail = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rm;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      run_w(ra, rb, rm, pw, lat);
      check($sformatf("wide_%0d_a%0h_b%0h_m%0d", i, ra, rb, rm), 32'(pw), 32'(ref_w(ra, rb, rm)));
      if (lat != 8) begin
        lfail++;
        $display("FAIL wide_latency_%0d: got %0d expected 8", i, lat);
      end
    end
    check("wide_latency_errors", 32'(lfail), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
